// File: rtl/buzz_pkg.sv
// Shared types for the buzzer activity decoder: channel activity classes,
// event FSM states and the event code width.
package buzz_pkg;

    localparam int unsigned EVT_CODE_W = 2;

    typedef enum logic [EVT_CODE_W-1:0] {
        SILENT = 2'b00,
        STEADY = 2'b01,
        TONE   = 2'b10,
        GLITCH = 2'b11
    } buzz_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } evt_state_e;

endpackage

// File: rtl/buzz_chan_meter.sv
// Per-channel buzzer meter: 2-flop synchroniser, both-edge detector,
// saturating edge counter and end-of-window classifier.
module buzz_chan_meter
    import buzz_pkg::*;
#(
    parameter int unsigned MIN_TOGGLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        win_end,
    input  logic        buzz_in,
    output buzz_class_e cls,
    output logic        changed
);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    buzz_class_e      cls_q;
    buzz_class_e      cls_d;
    logic             toggle;
    logic [CNT_W:0]   total;

    // Synchroniser, edge history, edge counter and class registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            cls_q   <= SILENT;
        end else begin
            sync1_q <= buzz_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
        end
    end

    // Count edges; at window end classify (including an edge on that very cycle) and restart.
    always_comb begin
        toggle  = sync2_q ^ prev_q;
        total   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, toggle};
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        changed = 1'b0;
        if (ena && toggle && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (win_end) begin
            cnt_d = '0;
            if (total == '0) begin
                cls_d = sync2_q ? STEADY : SILENT;
            end else if (total >= (CNT_W+1)'(MIN_TOGGLES)) begin
                cls_d = TONE;
            end else begin
                cls_d = GLITCH;
            end
            changed = (cls_d != cls_q);
        end
    end

    assign cls = cls_q;

endmodule

// File: rtl/buzzer_activity_decoder.sv
// Buzzer activity decoder top: window counter, per-channel meters, pending
// change vector, lowest-index picker, valid/ready event FSM and status.
// Optional feature macro: STICKY_LATCH_EN (sticky TONE status with clear).
module buzzer_activity_decoder
    import buzz_pkg::*;
#(
    parameter int unsigned NCH         = 8,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned MIN_TOGGLES = 4,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NCH-1:0]        buzz_in,
    input  logic                  clear,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CW-1:0]         evt_chan,
    output logic [EVT_CODE_W-1:0] evt_code,
    output logic [NCH-1:0]        status
);

    localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [WW-1:0]  win_q;
    logic [WW-1:0]  win_d;
    logic           win_end;
    buzz_class_e    cls [NCH];
    logic [NCH-1:0] changed;
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] pending_d;
    logic [NCH-1:0] clr_mask;
    logic [NCH-1:0] tone_map;
    logic [CW-1:0]  pick_idx;
    logic           pick_found;
    evt_state_e     state_q;
    evt_state_e     state_d;
    logic [CW-1:0]  chan_q;
    logic [CW-1:0]  chan_d;
    buzz_class_e    code_q;
    buzz_class_e    code_d;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        buzz_chan_meter #(
            .MIN_TOGGLES (MIN_TOGGLES),
            .CNT_W       (CNT_W)
        ) u_meter (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .win_end (win_end),
            .buzz_in (buzz_in[g]),
            .cls     (cls[g]),
            .changed (changed[g])
        );
    end

    // Window counter advances only while measuring.
    always_comb begin
        win_end = ena && (win_q == WW'(WINDOW - 1));
        win_d   = win_q;
        if (ena) begin
            win_d = win_end ? '0 : win_q + 1'b1;
        end
    end

    // Lowest-index pending channel.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pending_q[i] && !pick_found) begin
                pick_idx   = CW'(i);
                pick_found = 1'b1;
            end
        end
    end

    // Event FSM next state; LOAD samples the channel's newest class. A new change wins over the clear.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        code_d   = code_q;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                chan_d             = pick_idx;
                code_d             = cls[pick_idx];
                clr_mask[pick_idx] = 1'b1;
                state_d            = ST_SEND;
            end
            ST_SEND: begin
                if (evt_ready) state_d = (|pending_q) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pending_d = (pending_q & ~clr_mask) | changed;
    end

    // Window counter, pending vector and event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            code_q    <= SILENT;
        end else begin
            win_q     <= win_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            chan_q    <= chan_d;
            code_q    <= code_d;
        end
    end

    // Live TONE bitmap from the registered classes.
    always_comb begin
        tone_map = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            tone_map[i] = (cls[i] == TONE);
        end
    end

`ifdef STICKY_LATCH_EN
    logic [NCH-1:0] sticky_q;
    logic [NCH-1:0] sticky_d;

    // Sticky bits collect TONE; clear reloads from the live map so a concurrent TONE survives.
    always_comb begin
        sticky_d = clear ? tone_map : (sticky_q | tone_map);
        status   = sticky_q | tone_map;
    end

    // Sticky register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= sticky_d;
    end
`else
    logic unused_clear;

    // Status is the live TONE bitmap; clear has no effect.
    always_comb begin
        unused_clear = clear;
        status       = tone_map;
    end
`endif

    assign evt_valid = (state_q == ST_SEND);
    assign evt_chan  = chan_q;
    assign evt_code  = code_q;

endmodule

// File: tb/tb_buzzer_activity_decoder.sv
// Self-checking bench for buzzer_activity_decoder (WINDOW=16, MIN_TOGGLES=4).
// Each window schedules k toggles per channel mid-window; the reference
// derives classes from k and the final level, and expects one event per
// changed channel in ascending channel order.
module tb_buzzer_activity_decoder;

    localparam int unsigned NCH = 8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] buzz_in;
    logic       clear;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_chan;
    logic [1:0] evt_code;
    logic [7:0] status;

    int          checks;
    int          errors;
    int unsigned ktog [NCH];
    logic [1:0]  cls_m [NCH];
    logic [7:0]  sticky_m;
    int          exp_q [$];
    int          got_q [$];
    int          got_rd;
    bit          seen_valid;

    buzzer_activity_decoder #(
        .NCH         (8),
        .WINDOW      (16),
        .MIN_TOGGLES (4),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .buzz_in   (buzz_in),
        .clear     (clear),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_code  (evt_code),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer: record each accepted event (inputs change 2 ns after posedge, so negedge is stable).
    always @(negedge clk) begin
        if (rst_n && evt_valid) seen_valid <= 1'b1;
        if (rst_n && evt_valid && evt_ready) got_q.push_back(int'({evt_chan, evt_code}));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tone_m();
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < NCH; i++) t[i] = (cls_m[i] == 2'b10);
        return t;
    endfunction

    function automatic logic [7:0] status_exp();
`ifdef STICKY_LATCH_EN
        return sticky_m | tone_m();
`else
        return tone_m();
`endif
    endfunction

    function automatic logic [1:0] class_of(input int unsigned k, input logic lvl);
        if (k == 0) return lvl ? 2'b01 : 2'b00;
        if (k >= 4) return 2'b10;
        return 2'b11;
    endfunction

    // One measurement window of 16 enabled cycles; toggles at offsets 3,5,..,13.
    task automatic run_window();
        logic [1:0] nc;
        ena = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c >= 3 && ((c - 3) % 2) == 0) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (int'((c - 3) / 2) < int'(ktog[ch])) buzz_in[ch] = ~buzz_in[ch];
                end
            end
            @(posedge clk);
            #2;
        end
        ena = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            nc = class_of(ktog[ch], buzz_in[ch]);
            if (nc != cls_m[ch]) exp_q.push_back(ch * 4 + int'(nc));
            cls_m[ch] = nc;
        end
        sticky_m = sticky_m | tone_m();
    endtask

    task automatic set_k(input int unsigned k0, k1, k2, k3, k4, k5, k6, k7);
        ktog[0] = k0; ktog[1] = k1; ktog[2] = k2; ktog[3] = k3;
        ktog[4] = k4; ktog[5] = k5; ktog[6] = k6; ktog[7] = k7;
    endtask

    task automatic drain_check(input string tag);
        repeat (60) @(posedge clk);
        #2;
        chk({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_rd + i < got_q.size()) chk({tag, "_evt"}, 32'(got_q[got_rd + i]), 32'(exp_q[i]));
        end
        got_rd = got_q.size();
        exp_q.delete();
        chk({tag, "_status"}, 32'(status), 32'(status_exp()));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #2;
        clear = 1'b0;
        sticky_m = tone_m();
    endtask

    initial begin
        int wait_cnt;
        checks = 0; errors = 0; got_rd = 0; seen_valid = 1'b0;
        sticky_m = '0;
        for (int i = 0; i < NCH; i++) begin cls_m[i] = 2'b00; ktog[i] = 0; end
        rst_n = 1'b0; ena = 1'b0; buzz_in = '0; clear = 1'b0; evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_chan", 32'(evt_chan), 32'd0);
        chk("rst_code", 32'(evt_code), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        #1;

        // Quiet line for three windows.
        set_k(0, 0, 0, 0, 0, 0, 0, 0);
        for (int w = 0; w < 3; w++) begin
            run_window();
            drain_check("quiet");
        end
        chk("quiet_no_valid", 32'(seen_valid), 32'd0);

        // Channel 0 tone.
        set_k(6, 0, 0, 0, 0, 0, 0, 0);
        run_window();
        drain_check("tone0");
        chk("tone0_status", 32'(status), 32'h01);

        // Channels 1,2 go high (one edge) then held steady.
        set_k(6, 1, 1, 0, 0, 0, 0, 0);
        run_window();
        drain_check("rise12");
        set_k(6, 0, 0, 0, 0, 0, 0, 0);
        run_window();
        drain_check("steady12");
        chk("steady12_status", 32'(status), 32'h01);

        // Single pulse on channel 5, then quiet.
        set_k(6, 0, 0, 0, 0, 2, 0, 0);
        set_k(6, 0, 0, 0, 0, 2, 0, 0);
        ktog[5] = 2; ktog[4] = 0;
        run_window();
        drain_check("pulse5");
        ktog[5] = 0;
        run_window();
        drain_check("quiet5");

        // Threshold boundary: 3 edges -> GLITCH, 4 edges -> TONE.
        set_k(6, 0, 0, 3, 4, 0, 0, 0);
        run_window();
        drain_check("thresh");

        // Reset all to level-based classes, then all TONE under back-pressure.
        set_k(0, 0, 0, 0, 0, 0, 0, 0);
        run_window();
        drain_check("flat");
        pulse_clear();
        drain_check("clear_flat");
        evt_ready = 1'b0;
        set_k(6, 6, 6, 6, 6, 6, 6, 6);
        run_window();
        wait_cnt = 0;
        while (!evt_valid && wait_cnt < 10) begin
            @(posedge clk);
            #2;
            wait_cnt++;
        end
        chk("bp_valid_timeout", 32'(evt_valid), 32'd1);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            chk("bp_hold_valid", 32'(evt_valid), 32'd1);
            chk("bp_hold_chan", 32'(evt_chan), 32'd0);
        end
        chk("bp_code", 32'(evt_code), 32'd2);
        evt_ready = 1'b1;
        drain_check("bp_release");

        // Clear while tones are live, then tones stop and clear again.
        pulse_clear();
        drain_check("clear_tone");
        set_k(0, 0, 0, 0, 0, 0, 0, 0);
        run_window();
        drain_check("tone_off");
        pulse_clear();
        drain_check("clear_off");

        // Randomized windows.
        for (int w = 0; w < 20; w++) begin
            for (int ch = 0; ch < NCH; ch++) ktog[ch] = $urandom_range(0, 6);
            run_window();
            if (($urandom % 4) == 0) pulse_clear();
            drain_check("rand");
        end

        // Reset during an outstanding event.
        evt_ready = 1'b0;
        for (int ch = 0; ch < NCH; ch++) ktog[ch] = (cls_m[ch] == 2'b10) ? 0 : 6;
        run_window();
        exp_q.delete();
        wait_cnt = 0;
        while (!evt_valid && wait_cnt < 10) begin
            @(posedge clk);
            #2;
            wait_cnt++;
        end
        chk("mid_valid_timeout", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_status", 32'(status), 32'd0);
        chk("mid_rst_chan", 32'(evt_chan), 32'd0);
        #20;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
